// File: rtl/spi_frame_sequencer.sv
// Issues a multi-byte SPI command frame to a byte-wide master and returns the gathered rx frame.
// Optional per-byte watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_frame_sequencer #(
    parameter int WIDTH          = 8,
    parameter int MAX_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int LW = $clog2(MAX_BYTES + 1),
    localparam int FW = WIDTH * MAX_BYTES
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [FW-1:0]    cmd_tx_i,
    input  logic [LW-1:0]    cmd_len_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [FW-1:0]    rsp_data_o,
    output logic             rsp_err_o,
    output logic             spi_start_o,
    output logic [WIDTH-1:0] spi_tx_o,
    input  logic             spi_done_i,
    input  logic [WIDTH-1:0] spi_rx_i,
    output logic             frame_cs_o
);

    if (MAX_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("spi_frame_sequencer: MAX_BYTES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] tx_frame;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic          accept;
    logic          bad_len;
    logic          more;
    logic          timeout;

    function automatic logic [WIDTH-1:0] byte_at(input logic [FW-1:0] v, input int k);
        byte_at = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (b == k) byte_at = v[b*WIDTH +: WIDTH];
        end
    endfunction

    assign cmd_ready_o = (state == IDLE) && reset_ni;
    assign rsp_valid_o = (state == RESP);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign bad_len     = (cmd_len_i == '0) || (int'(cmd_len_i) > MAX_BYTES);
    assign more        = (int'(idx) + 1) < int'(len);

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd <= '0;
        end else if (state != WAIT || spi_done_i) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    assign timeout = (state == WAIT) && !spi_done_i &&
                     (wd == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The restart in WAIT is Mealy so the master sees no idle gap between bytes.
    always_comb begin
        state_next  = state;
        spi_start_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = bad_len ? RESP : ISSUE;
            end
            ISSUE: begin
                spi_start_o = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (spi_done_i) begin
                    if (more) spi_start_o = 1'b1;
                    else      state_next  = RESP;
                end else if (timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // spi_tx_o always runs one byte ahead once the current byte has started.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_frame   <= '0;
            len        <= '0;
            idx        <= '0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
            spi_tx_o   <= '0;
            frame_cs_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tx_frame   <= cmd_tx_i;
                        len        <= cmd_len_i;
                        idx        <= '0;
                        rsp_data_o <= '0;
                        rsp_err_o  <= bad_len;
                        if (!bad_len) begin
                            spi_tx_o   <= cmd_tx_i[WIDTH-1:0];
                            frame_cs_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (more) spi_tx_o <= byte_at(tx_frame, int'(idx) + 1);
                end
                WAIT: begin
                    if (spi_done_i) begin
                        for (int k = 0; k < MAX_BYTES; k++) begin
                            if (k == int'(idx)) rsp_data_o[k*WIDTH +: WIDTH] <= spi_rx_i;
                        end
                        if (more) begin
                            idx <= idx + 1'b1;
                            if ((int'(idx) + 2) < int'(len)) begin
                                spi_tx_o <= byte_at(tx_frame, int'(idx) + 2);
                            end
                        end else begin
                            frame_cs_o <= 1'b0;
                            rsp_err_o  <= 1'b0;
                        end
                    end else if (timeout) begin
                        frame_cs_o <= 1'b0;
                        rsp_err_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer with a behavioural SPI master model.
// Define SPI_SEQ_TIMEOUT_EN to also exercise the watchdog abort.
module tb_spi_frame_sequencer;

    logic        clock_i;
    logic        reset_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_tx_i;
    logic [2:0]  cmd_len_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        spi_start_o;
    logic [7:0]  spi_tx_o;
    logic        spi_done_i;
    logic [7:0]  spi_rx_i;
    logic        frame_cs_o;

    spi_frame_sequencer #(
        .WIDTH(8), .MAX_BYTES(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_tx_i(cmd_tx_i), .cmd_len_i(cmd_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .spi_start_o(spi_start_o), .spi_tx_o(spi_tx_o),
        .spi_done_i(spi_done_i), .spi_rx_i(spi_rx_i),
        .frame_cs_o(frame_cs_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t       expq[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int restarts = 0;
    int skip_after = -1;
    bit hung = 0;
    int hold_mode = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s bound expired", name);
    endtask

    initial begin
        clock_i = 0;
        forever #5 clock_i = ~clock_i;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    // SPI master model: random byte latency, optional hang, stray done pulses when idle.
    initial begin : master
        int cnt;
        bit busy;
        bit real_done;
        spi_done_i = 0;
        spi_rx_i   = 0;
        busy = 0;
        cnt  = 0;
        forever begin
            @(negedge clock_i);
            spi_done_i = 0;
            real_done  = 0;
            if (!reset_ni) begin
                busy = 0;
                hung = 0;
                continue;
            end
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    real_done = 1;
                    spi_done_i = 1;
                    spi_rx_i = (rxq.size() > 0) ? rxq.pop_front() : 8'hEE;
                end
            end else if (!hung && $urandom_range(0, 4) == 0) begin
                spi_done_i = 1;
                spi_rx_i = 8'($urandom);
            end
            #1;
            if (spi_start_o) begin
                starts++;
                if (real_done) restarts++;
                chk("frame_cs_at_start", frame_cs_o, 1);
                chk("start_expected", txq.size() > 0, 1);
                if (txq.size() > 0) chk("spi_tx", spi_tx_o, txq.pop_front());
                if (skip_after == 0) begin
                    hung = 1;
                    skip_after = -1;
                end else begin
                    if (skip_after > 0) skip_after--;
                    busy = 1;
                    cnt = $urandom_range(1, 5);
                end
            end
        end
    end

    initial begin : monitor
        rsp_t e;
        rsp_ready_i = 0;
        forever begin
            @(negedge clock_i);
            rsp_ready_i = (hold_mode == 1) ? 1'b0 :
                          (hold_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #2;
            if (reset_ni && rsp_valid_o) begin
                chk("frame_cs_in_resp", frame_cs_o, 0);
                if (rsp_ready_i) begin
                    chk("rsp_expected", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        chk("rsp_data", rsp_data_o, e.data);
                        chk("rsp_err", rsp_err_o, e.err);
                    end
                end
            end
        end
    end

    // Reference: bytes 0..len-1 go out in order; rx bytes pack low-first; bad len -> err.
    task automatic push_expect(input logic [31:0] tx, input int len,
                               input logic [31:0] rx, input int abort_at);
        rsp_t e;
        e.data = '0;
        e.err  = 0;
        if (len < 1 || len > 4) begin
            e.err = 1;
        end else begin
            for (int k = 0; k < len; k++) begin
                if (abort_at < 0 || k <= abort_at) txq.push_back(tx[k*8 +: 8]);
                if (abort_at < 0 || k < abort_at) begin
                    rxq.push_back(rx[k*8 +: 8]);
                    e.data[k*8 +: 8] = rx[k*8 +: 8];
                end
            end
            e.err = (abort_at >= 0);
        end
        expq.push_back(e);
    endtask

    task automatic issue(input logic [31:0] tx, input int len,
                         input logic [31:0] rx, input int abort_at);
        int waited;
        bit ok;
        push_expect(tx, len, rx, abort_at);
        @(negedge clock_i);
        cmd_valid_i = 1;
        cmd_tx_i    = tx;
        cmd_len_i   = 3'(len);
        waited = 0;
        ok = 0;
        while (!ok && waited < 300) begin
            #1;
            ok = cmd_ready_o;
            if (!ok) begin
                @(negedge clock_i);
                waited++;
            end
        end
        if (!ok) fail("cmd_accept");
        @(posedge clock_i);
        #1;
        cmd_valid_i = 0;
        cmd_tx_i    = $urandom;
        cmd_len_i   = 3'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while ((expq.size() != 0 || !cmd_ready_o) && w < budget) begin
            @(negedge clock_i);
            #3;
            w++;
        end
        if (w >= budget) fail("wait_idle");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_rsp_err"}, rsp_err_o, 0);
        chk({tag, "_spi_start"}, spi_start_o, 0);
        chk({tag, "_frame_cs"}, frame_cs_o, 0);
        chk({tag, "_spi_tx"}, spi_tx_o, 0);
        chk({tag, "_rsp_data"}, rsp_data_o, 0);
    endtask

    initial begin : stim
        int s0;
        int r0;
        int w;
        logic [31:0] snap_data;
        logic        snap_err;
        reset_ni    = 0;
        cmd_valid_i = 0;
        cmd_tx_i    = 0;
        cmd_len_i   = 0;
        repeat (3) @(negedge clock_i);
        #1;
        chk_all_zero("reset");
        @(negedge clock_i);
        reset_ni = 1;
        #1;
        chk("ready_after_reset", cmd_ready_o, 1);

        s0 = starts; r0 = restarts;
        issue(32'h0000_00A5, 1, 32'h0000_003C, -1);
        wait_idle(400);
        chk("single_starts", starts - s0, 1);
        chk("single_restarts", restarts - r0, 0);

        s0 = starts; r0 = restarts;
        issue(32'h4433_2211, 4, 32'hD4D3_D2D1, -1);
        wait_idle(400);
        chk("full_starts", starts - s0, 4);
        chk("full_restarts", restarts - r0, 3);

        s0 = starts;
        issue(32'h1234_5678, 0, 32'h0, -1);
        wait_idle(400);
        issue(32'h8765_4321, 5, 32'h0, -1);
        wait_idle(400);
        chk("illegal_starts", starts - s0, 0);

        hold_mode = 1;
        issue(32'h0000_BEEF, 2, 32'h0000_9A8B, -1);
        w = 0;
        while (!rsp_valid_o && w < 200) begin
            @(negedge clock_i);
            #3;
            w++;
        end
        if (w >= 200) fail("bp_rsp_valid");
        snap_data = rsp_data_o;
        snap_err  = rsp_err_o;
        push_expect(32'h0000_005A, 1, 32'h0000_0077, -1);
        @(negedge clock_i);
        cmd_valid_i = 1;
        cmd_tx_i    = 32'h0000_005A;
        cmd_len_i   = 3'd1;
        repeat (20) begin
            @(negedge clock_i);
            #3;
            chk("bp_valid_held", rsp_valid_o, 1);
            chk("bp_data_stable", rsp_data_o, snap_data);
            chk("bp_err_stable", rsp_err_o, snap_err);
            chk("bp_cmd_ready", cmd_ready_o, 0);
        end
        hold_mode = 2;
        @(negedge clock_i);
        #3;
        @(posedge clock_i);
        #1;
        chk("bp_valid_dropped", rsp_valid_o, 0);
        chk("bp_ready_next", cmd_ready_o, 1);
        @(posedge clock_i);
        #1;
        chk("bp_accepted", cmd_ready_o, 0);
        chk("bp_cs_up", frame_cs_o, 1);
        cmd_valid_i = 0;
        hold_mode = 0;
        wait_idle(400);

        for (int i = 0; i < 25; i++) begin
            issue($urandom, int'($urandom_range(0, 5)), $urandom, -1);
        end
        wait_idle(3000);

        s0 = starts;
        issue(32'h00C3_B2A1, 3, 32'h0033_2211, -1);
        w = 0;
        while (starts < s0 + 2 && w < 100) begin
            @(negedge clock_i);
            #2;
            w++;
        end
        if (w >= 100) fail("mid_frame_second_byte");
        @(negedge clock_i);
        #3;
        reset_ni = 0;
        #1;
        chk_all_zero("midreset");
        txq.delete();
        rxq.delete();
        expq.delete();
        repeat (2) @(negedge clock_i);
        #3;
        reset_ni = 1;
        issue(32'h0000_6655, 2, 32'h0000_E2E1, -1);
        wait_idle(400);

`ifdef SPI_SEQ_TIMEOUT_EN
        skip_after = 1;
        issue(32'h00CC_BBAA, 3, 32'h0000_0F0E, 1);
        wait_idle(400);
        hung = 0;
`endif

        chk("txq_drained", txq.size(), 0);
        chk("rxq_drained", rxq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
